spi_tx_ctrl: RTL and testbench

//  Transaction sequencer for the SPI transmit shifter. Accepts one command (bit length, target chip-select),

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_clk_div.sv | 46 ++++
 rtl/spi_tx_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_spi_tx_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit sequencer: FSM state encoding,
// default CS setup/hold timing and the transfer-length width.
// Optional feature macro: SPI_CS_GAP_EN (adds the ST_GAP state).
package spi_pkg;

   localparam int SPI_LEN_W        = 16;
   localparam int SPI_CS_SETUP_DEF = 2;
   localparam int SPI_CS_HOLD_DEF  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_DONE
`ifdef SPI_CS_GAP_EN
      , ST_GAP
`endif
   } spi_state_t;

   // Width of a chip-select index; a single CS line still gets one bit.
   function automatic int spi_cs_w(input int num_cs);
      return (num_cs > 1) ? $clog2(num_cs) : 1;
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCK generator: half-period divider plus SCK toggle flop. While en is high
// the counter runs 0..div and SCK toggles on terminal count; rise/fall are
// single-cycle strobes registered together with the new SCK level, so a fall
// strobe is high in the same cycle SCK reads low. en low parks SCK low and
// clears the counter.
module spi_clk_div import spi_pkg::*; #(
   parameter int DIV_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             sck,
   output logic             rise,
   output logic             fall
);

   logic [DIV_W-1:0] cnt;

   // Half-period counter and SCK toggle with edge strobes.
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt  <= '0;
         sck  <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else if (!en) begin
         cnt  <= '0;
         sck  <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else if (cnt == div) begin
         cnt  <= '0;
         sck  <= ~sck;
         rise <= ~sck;
         fall <= sck;
      end else begin
         cnt  <= cnt + DIV_W'(1);
         rise <= 1'b0;
         fall <= 1'b0;
      end
   end

endmodule

// File: rtl/spi_tx_ctrl.sv
// SPI transmit transaction sequencer (SCK mode 0).
// Accepts one command (length, CS index, SCK divider), loads the shifter
// length, drops the selected CS_n with setup time, runs SCK and the per-bit
// shift strobe, holds CS_n after the last falling edge, then pulses done_o
// (with err_o if the shifter's final-bit indication was early or missing).
// Optional feature macro: SPI_CS_GAP_EN adds cs_gap_i and a GAP state that
// keeps all CS_n high for cs_gap_i+1 cycles after done_o.
module spi_tx_ctrl import spi_pkg::*; #(
   parameter  int NUM_CS   = 4,
   parameter  int DIV_W    = 8,
   parameter  int CS_SETUP = SPI_CS_SETUP_DEF,
   parameter  int CS_HOLD  = SPI_CS_HOLD_DEF,
   localparam int CS_W     = spi_cs_w(NUM_CS)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cmd_vld_i,
   output logic                 cmd_rdy_o,
   input  logic [SPI_LEN_W-1:0] cmd_len_i,
   input  logic [CS_W-1:0]      cmd_cs_i,
   input  logic [DIV_W-1:0]     cmd_div_i,
   output logic [NUM_CS-1:0]    cs_n_o,
   output logic                 sck_o,
   output logic                 tx_en_o,
   output logic                 tx_edge_o,
   output logic [SPI_LEN_W-1:0] tx_bits_len_o,
   output logic                 tx_bits_len_update_o,
   input  logic                 tx_done_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o
`ifdef SPI_CS_GAP_EN
   ,
   input  logic [7:0]           cs_gap_i
`endif
);

   localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
   localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);

   spi_state_t           state;
   logic [15:0]          ph_cnt;
   logic [SPI_LEN_W-1:0] bit_cnt;
   logic [DIV_W-1:0]     div_q;
   logic [CS_W-1:0]      cs_q;
   logic                 err_flag;
`ifdef SPI_CS_GAP_EN
   logic [7:0]           gap_q;
   logic                 gap_pend;
`endif

   logic accept;
   logic cs_bad;
   logic last_fall;
   logic sck_en;
   logic div_sck;
   logic div_fall;
   logic sck_rise_unused;

   assign accept    = cmd_vld_i && cmd_rdy_o;
   assign cs_bad    = (int'(cmd_cs_i) >= NUM_CS);
   // The fall that completes the len-th bit ends SHIFT; that cycle already
   // counts as the first CS hold cycle.
   assign last_fall = (state == ST_SHIFT) && div_fall &&
                      ((bit_cnt + SPI_LEN_W'(1)) == tx_bits_len_o);
   // Stop the divider on the final fall so SCK cannot rise again (div==0).
   assign sck_en    = tx_en_o && !last_fall;

   assign sck_o     = div_sck;
   assign tx_edge_o = div_fall;

   spi_clk_div #(
      .DIV_W (DIV_W)
   ) u_clk_div (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en    (sck_en),
      .div   (div_q),
      .sck   (div_sck),
      .rise  (sck_rise_unused),
      .fall  (div_fall)
   );

   // Transaction FSM with registered outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state                <= ST_IDLE;
         ph_cnt               <= '0;
         bit_cnt              <= '0;
         div_q                <= '0;
         cs_q                 <= '0;
         err_flag             <= 1'b0;
         cmd_rdy_o            <= 1'b1;
         busy_o               <= 1'b0;
         cs_n_o               <= '1;
         tx_en_o              <= 1'b0;
         tx_bits_len_o        <= '0;
         tx_bits_len_update_o <= 1'b0;
         done_o               <= 1'b0;
         err_o                <= 1'b0;
`ifdef SPI_CS_GAP_EN
         gap_q                <= '0;
         gap_pend             <= 1'b0;
`endif
      end else begin
         // NOTE: strobes default low each cycle so a branch that forgets them
         // cannot leave a pulse stuck high.
         tx_bits_len_update_o <= 1'b0;
         done_o               <= 1'b0;
         err_o                <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (accept) begin
                  cmd_rdy_o <= 1'b0;
                  busy_o    <= 1'b1;
                  err_flag  <= 1'b0;
                  div_q     <= cmd_div_i;
                  cs_q      <= cmd_cs_i;
`ifdef SPI_CS_GAP_EN
                  gap_q     <= cs_gap_i;
`endif
                  if ((cmd_len_i == '0) || cs_bad) begin
                     // Nothing to shift: report completion without touching CS.
                     state  <= ST_DONE;
                     done_o <= 1'b1;
                     err_o  <= cs_bad;
                  end else begin
                     state                <= ST_LOAD;
                     tx_bits_len_o        <= cmd_len_i;
                     tx_bits_len_update_o <= 1'b1;
                  end
               end
            end

            ST_LOAD: begin
               cs_n_o[cs_q] <= 1'b0;
               ph_cnt       <= '0;
               state        <= ST_SETUP;
`ifdef SPI_CS_GAP_EN
               gap_pend     <= 1'b1;
`endif
            end

            ST_SETUP: begin
               if (ph_cnt == SETUP_LAST) begin
                  state   <= ST_SHIFT;
                  tx_en_o <= 1'b1;
                  bit_cnt <= '0;
               end else begin
                  ph_cnt <= ph_cnt + 16'd1;
               end
            end

            ST_SHIFT: begin
               if (div_fall) begin
                  bit_cnt <= bit_cnt + SPI_LEN_W'(1);
               end
               if (last_fall) begin
                  tx_en_o <= 1'b0;
                  if (!tx_done_i) begin
                     err_flag <= 1'b1;
                  end
                  if (CS_HOLD == 1) begin
                     cs_n_o <= '1;
                     done_o <= 1'b1;
                     err_o  <= err_flag | ~tx_done_i;
                     state  <= ST_DONE;
                  end else begin
                     ph_cnt <= 16'd1;
                     state  <= ST_HOLD;
                  end
               end else if (tx_done_i) begin
                  // Shifter claims its final bit before the sequencer is done.
                  err_flag <= 1'b1;
               end
            end

            ST_HOLD: begin
               if (ph_cnt == HOLD_LAST) begin
                  cs_n_o <= '1;
                  done_o <= 1'b1;
                  err_o  <= err_flag;
                  state  <= ST_DONE;
               end else begin
                  ph_cnt <= ph_cnt + 16'd1;
               end
            end

            ST_DONE: begin
`ifdef SPI_CS_GAP_EN
               if (gap_pend) begin
                  gap_pend <= 1'b0;
                  ph_cnt   <= '0;
                  state    <= ST_GAP;
               end else
`endif
               begin
                  state     <= ST_IDLE;
                  cmd_rdy_o <= 1'b1;
                  busy_o    <= 1'b0;
               end
            end

`ifdef SPI_CS_GAP_EN
            ST_GAP: begin
               if (ph_cnt == {8'h00, gap_q}) begin
                  state     <= ST_IDLE;
                  cmd_rdy_o <= 1'b1;
                  busy_o    <= 1'b0;
               end else begin
                  ph_cnt <= ph_cnt + 16'd1;
               end
            end
`endif

            default: begin
               state     <= ST_IDLE;
               cmd_rdy_o <= 1'b1;
               busy_o    <= 1'b0;
               tx_en_o   <= 1'b0;
               cs_n_o    <= '1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_tx_ctrl.sv
// Directed self-checking bench for spi_tx_ctrl (default parameters).
// A small shifter model drives tx_done_i on the len-th shift strobe, or
// early/never when the error paths are exercised.
`timescale 1ns/1ps
module tb_spi_tx_ctrl;

   logic        clk_i     = 1'b0;
   logic        rst_i     = 1'b1;
   logic        cmd_vld_i = 1'b0;
   logic        cmd_rdy_o;
   logic [15:0] cmd_len_i = '0;
   logic [1:0]  cmd_cs_i  = '0;
   logic [7:0]  cmd_div_i = '0;
   logic [3:0]  cs_n_o;
   logic        sck_o;
   logic        tx_en_o;
   logic        tx_edge_o;
   logic [15:0] tx_bits_len_o;
   logic        tx_bits_len_update_o;
   logic        tx_done_i;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
`ifdef SPI_CS_GAP_EN
   logic [7:0]  cs_gap_i = 8'd3;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   spi_tx_ctrl dut (
      .clk_i                (clk_i),
      .rst_i                (rst_i),
      .cmd_vld_i            (cmd_vld_i),
      .cmd_rdy_o            (cmd_rdy_o),
      .cmd_len_i            (cmd_len_i),
      .cmd_cs_i             (cmd_cs_i),
      .cmd_div_i            (cmd_div_i),
      .cs_n_o               (cs_n_o),
      .sck_o                (sck_o),
      .tx_en_o              (tx_en_o),
      .tx_edge_o            (tx_edge_o),
      .tx_bits_len_o        (tx_bits_len_o),
      .tx_bits_len_update_o (tx_bits_len_update_o),
      .tx_done_i            (tx_done_i),
      .busy_o               (busy_o),
      .done_o               (done_o),
      .err_o                (err_o)
`ifdef SPI_CS_GAP_EN
      ,
      .cs_gap_i             (cs_gap_i)
`endif
   );

   // Shifter model: 0 = never signal done, 1 = on the last strobe, 2 = on the first.
   int shf_cnt   = 0;
   int done_mode = 1;
   always @(posedge clk_i) begin
      if (tx_bits_len_update_o) shf_cnt <= 0;
      else if (tx_edge_o)       shf_cnt <= shf_cnt + 1;
   end
   assign tx_done_i = tx_edge_o &&
                      (((done_mode == 1) && (shf_cnt == int'(tx_bits_len_o) - 1)) ||
                       ((done_mode == 2) && (shf_cnt == 0)));

   // Running activity counters sampled on the falling clock edge.
   int         n_rise = 0, n_edge = 0, n_cslow = 0, n_cs_sel = 0, n_done = 0, n_upd = 0;
   logic       prev_sck = 1'b0;
   logic       last_err = 1'b0;
   logic [3:0] sel_pat  = 4'hF;
   always @(negedge clk_i) begin
      if (sck_o && !prev_sck) n_rise++;
      prev_sck = sck_o;
      if (tx_edge_o) n_edge++;
      if (cs_n_o != 4'hF) n_cslow++;
      if (cs_n_o == sel_pat) n_cs_sel++;
      if (tx_bits_len_update_o) n_upd++;
      if (done_o) begin
         n_done++;
         last_err = err_o;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
      #1;
   endtask

   // Present a command, wait for ready, let it be accepted, then drop valid.
   task automatic send_cmd(input int len, input int cs, input int div);
      int n = 0;
      cmd_len_i = 16'(len);
      cmd_cs_i  = 2'(cs);
      cmd_div_i = 8'(div);
      cmd_vld_i = 1'b1;
      while (!cmd_rdy_o && n < 1000) begin
         tick();
         n++;
      end
      check("cmd_rdy_before_accept", 32'(cmd_rdy_o), 1);
      @(posedge clk_i);
      tick();
      cmd_vld_i = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done_o && n < budget) begin
         tick();
         n++;
      end
      check("done_within_budget", 32'(done_o), 1);
   endtask

   initial begin
      int r0, e0, c0, s0, d0, u0, n;

      // ---------------- reset state
      repeat (3) tick();
      rst_i = 1'b0;
      tick();
      check("rst_cs_n",    32'(cs_n_o), 32'hF);
      check("rst_rdy",     32'(cmd_rdy_o), 1);
      check("rst_busy",    32'(busy_o), 0);
      check("rst_sck",     32'(sck_o), 0);
      check("rst_tx_en",   32'(tx_en_o), 0);
      check("rst_done",    32'(done_o), 0);
      check("rst_len",     32'(tx_bits_len_o), 0);
      check("rst_len_upd", 32'(tx_bits_len_update_o), 0);

      // ---------------- 1: len=8 cs=2 div=1
      sel_pat = 4'b1011;
      r0 = n_rise; e0 = n_edge; c0 = n_cslow; s0 = n_cs_sel; d0 = n_done;
      send_cmd(8, 2, 1);
      check("t1_len_upd", 32'(tx_bits_len_update_o), 1);
      check("t1_len",     32'(tx_bits_len_o), 8);
      check("t1_busy",    32'(busy_o), 1);
      check("t1_rdy_low", 32'(cmd_rdy_o), 0);
      wait_done(300);
      check("t1_err",       32'(err_o), 0);
      check("t1_cs_rel",    32'(cs_n_o), 32'hF);
      check("t1_rdy_at_dn", 32'(cmd_rdy_o), 0);
      tick();
      check("t1_rdy_after", 32'(cmd_rdy_o), 1);
      check("t1_done_1cyc", 32'(done_o), 0);
      check("t1_rises",     32'(n_rise - r0), 8);
      check("t1_edges",     32'(n_edge - e0), 8);
      check("t1_cs_cycles", 32'(n_cs_sel - s0), 36);
      check("t1_cslow_any", 32'(n_cslow - c0), 36);
      check("t1_done_cnt",  32'(n_done - d0), 1);

      // ---------------- 2: len=0
      r0 = n_rise; c0 = n_cslow; u0 = n_upd;
      cmd_len_i = 16'd0; cmd_cs_i = 2'd1; cmd_vld_i = 1'b1;
      @(posedge clk_i);
      tick();
      cmd_vld_i = 1'b0;
      check("t2_rdy_low", 32'(cmd_rdy_o), 0);
      check("t2_done",    32'(done_o), 1);
      check("t2_err",     32'(err_o), 0);
      check("t2_cs_n",    32'(cs_n_o), 32'hF);
      tick();
      check("t2_rdy_back", 32'(cmd_rdy_o), 1);
      check("t2_done_off", 32'(done_o), 0);
      check("t2_no_sck",   32'(n_rise - r0), 0);
      check("t2_no_cs",    32'(n_cslow - c0), 0);
      check("t2_no_upd",   32'(n_upd - u0), 0);
      check("t2_len_held", 32'(tx_bits_len_o), 8);

      // ---------------- 3: len=40 div=0, tx_done_i never asserted
      done_mode = 0;
      sel_pat = 4'b1101;
      e0 = n_edge; s0 = n_cs_sel;
      send_cmd(40, 1, 0);
      wait_done(500);
      check("t3_err",       32'(err_o), 1);
      check("t3_edges",     32'(n_edge - e0), 40);
      check("t3_cs_cycles", 32'(n_cs_sel - s0), 84);
      tick();
      done_mode = 1;
      send_cmd(3, 0, 0);
      wait_done(200);
      check("t3_err_cleared", 32'(err_o), 0);
      tick();
      // Early final-bit indication is also an error.
      done_mode = 2;
      send_cmd(4, 3, 0);
      wait_done(200);
      check("t3_early_err", 32'(err_o), 1);
      tick();
      done_mode = 1;

      // ---------------- 4: async reset on the 10th bit of len=32
      send_cmd(32, 3, 0);
      e0 = n_edge; n = 0;
      while ((n_edge - e0) < 10 && n < 500) begin
         tick();
         n++;
      end
      check("t4_reach_bit10", 32'(n_edge - e0), 10);
      #2 rst_i = 1'b1;
      #1;
      check("t4_cs_n",  32'(cs_n_o), 32'hF);
      check("t4_sck",   32'(sck_o), 0);
      check("t4_tx_en", 32'(tx_en_o), 0);
      check("t4_rdy",   32'(cmd_rdy_o), 1);
      check("t4_busy",  32'(busy_o), 0);
      d0 = n_done;
      repeat (3) tick();
      rst_i = 1'b0;
      repeat (100) tick();
      check("t4_no_done", 32'(n_done - d0), 0);

      // ---------------- 5: back-to-back with valid held high
      d0 = n_done; u0 = n_upd; e0 = n_edge;
      cmd_len_i = 16'd6; cmd_cs_i = 2'd0; cmd_div_i = 8'd0; cmd_vld_i = 1'b1;
      @(posedge clk_i);
      tick();
      check("t5_len_a", 32'(tx_bits_len_o), 6);
      cmd_len_i = 16'd5; cmd_cs_i = 2'd1; cmd_div_i = 8'd2;
      n = 0;
      while (!cmd_rdy_o && n < 1000) begin
         tick();
         n++;
      end
      check("t5_done_before_2nd", 32'(n_done - d0), 1);
      check("t5_len_still_a",     32'(tx_bits_len_o), 6);
      @(posedge clk_i);
      tick();
      cmd_vld_i = 1'b0;
      check("t5_len_b", 32'(tx_bits_len_o), 5);
      wait_done(500);
      check("t5_err", 32'(err_o), 0);
      tick();
      check("t5_upd_count", 32'(n_upd - u0), 2);
      check("t5_edges",     32'(n_edge - e0), 11);
      check("t5_done_cnt",  32'(n_done - d0), 2);

`ifdef SPI_CS_GAP_EN
      // ---------------- 6: CS gap of cs_gap_i+1 cycles after done
      begin
         int gap_cyc, cs_bad_cyc;
         gap_cyc = 0; cs_bad_cyc = 0;
         send_cmd(2, 0, 0);
         wait_done(200);
         tick();
         while (!cmd_rdy_o && gap_cyc < 50) begin
            gap_cyc++;
            if (cs_n_o != 4'hF) cs_bad_cyc++;
            tick();
         end
         check("t6_gap_cycles", 32'(gap_cyc), 4);
         check("t6_cs_high",    32'(cs_bad_cyc), 0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
